// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared state encoding and FIFO sizing for the ADC capture sequencer
package adc_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DONE, OVF} state_t;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int FIFO_DEPTH = 2**DEF_ADDR_WIDTH;
  localparam int FIFO_FULL_LVL = FIFO_DEPTH-1;
  function automatic int full_lvl(input int aw);
    return (1 << aw) - 1;
  endfunction
endpackage

// File: rtl/fifo_level_mon.sv
// fifo_level_mon: write-pointer mirror, filtered read-pointer sync and FIFO level/full
module fifo_level_mon
  import adc_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] rd_faddr,
  output logic [ADDR_WIDTH-1:0] level,
  output logic                  full
);
  localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(full_lvl(ADDR_WIDTH));
  logic [ADDR_WIDTH-1:0] s1, s2, s3, rptr, wptr, rptr_d, wptr_d, level_d;
  // wptr counts the write being issued this edge, so level already includes in-flight writes
  always_comb begin
    rptr_d = (s2 == s3) ? s2 : rptr;
    wptr_d = wptr + ADDR_WIDTH'(wr);
    level_d = wptr_d - rptr_d;
  end
  always_ff @(posedge clk)
    if (!reset) {s1, s2, s3, rptr, wptr, level, full} <= '0;
    else begin
      s1 <= rd_faddr;
      s2 <= s1;
      s3 <= s2;
      rptr <= rptr_d;
      wptr <= wptr_d;
      level <= level_d;
      full <= level_d == FULL;
    end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arms, triggers and writes decimated ADC samples into the sample FIFO
module adc_capture_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  trig_mode,
  input  logic                  trig,
  input  logic [7:0]            decim,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  input  logic                  adc_valid,
  input  logic [15:0]           adc_data,
  input  logic [ADDR_WIDTH-1:0] rd_faddr,
  output logic                  fifo_wr,
  output logic [15:0]           fifo_data,
  output logic [ADDR_WIDTH-1:0] level,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  captured
);
  state_t state, state_d;
  logic mode_q, trig_r1, trig_r2, full, accept, keep, wr_go, enter_cap;
  logic [7:0] decim_q, dcnt, dmax;
  logic [CNT_WIDTH-1:0] num_q;
  fifo_level_mon #(.ADDR_WIDTH(ADDR_WIDTH)) u_mon (
    .clk(clk),
    .reset(reset),
    .wr(wr_go),
    .rd_faddr(rd_faddr),
    .level(level),
    .full(full)
  );
  always_comb begin
    accept = start && !abort && (state == IDLE || state == DONE || state == OVF);
    dmax = (decim_q == 8'd0) ? 8'd0 : decim_q - 8'd1;
    keep = state == CAPTURE && adc_valid && dcnt == 8'd0;
    wr_go = keep && !full && !abort;
    state_d = state;
    if (abort) state_d = IDLE;
    else if (accept) state_d = ARMED;
    else if (state == ARMED && (!mode_q || (trig_r1 && !trig_r2)))
      state_d = (num_q == '0) ? DONE : CAPTURE;
    else if (keep && full) state_d = OVF;
    else if (wr_go && captured + CNT_WIDTH'(1) == num_q) state_d = DONE;
    enter_cap = state_d == CAPTURE && state != CAPTURE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      {mode_q, trig_r1, trig_r2, decim_q, num_q, dcnt} <= '0;
      {fifo_wr, fifo_data, busy, done, overflow, captured} <= '0;
    end else begin
      state <= state_d;
      trig_r1 <= trig;
      trig_r2 <= trig_r1;
      if (accept) {mode_q, decim_q, num_q} <= {trig_mode, decim, num_samples};
      dcnt <= enter_cap ? 8'd0 : (state == CAPTURE && adc_valid) ? ((dcnt >= dmax) ? 8'd0 : dcnt + 8'd1) : dcnt;
      fifo_wr <= wr_go;
      if (wr_go) fifo_data <= adc_data;
      captured <= enter_cap ? '0 : captured + CNT_WIDTH'(wr_go);
      busy <= state_d == ARMED || state_d == CAPTURE;
      done <= state_d == DONE;
      overflow <= state_d == OVF;
    end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer for the ADC sample FIFO. It arms on a host command and waits for an immediate or external trigger. It then writes a programmed number of (optionally decimated) ADC samples into the 16-bit sample FIFO by driving its data input and write-enable (`d_valid`). It tracks FIFO fill level against the host-side read pointer and stops cleanly on overflow. It sits between the ADC front end and the FIFO write port, in the FIFO's write clock domain.

## Interface
- `ADDR_WIDTH`, 9, FIFO address width; must match the FIFO instance.
- `CNT_WIDTH`, 16, width of sample-count registers.

- `clk`  in  1  system/ADC clock, same clock as the FIFO write side.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches config and arms. Ignored while `busy`.
- `abort`  in  1  one-cycle pulse; returns to IDLE from any state.
- `trig_mode`  in  1  0 = trigger immediately on arm; 1 = wait for external `trig` rising edge.
- `trig`  in  1  external trigger, already synchronous to `clk`.
- `decim`  in  8  keep one of every `decim` valid samples; 0 is treated as 1.
- `num_samples`  in  CNT_WIDTH  samples to store per capture.
- `adc_valid`  in  1  ADC sample strobe.
- `adc_data`  in  16  ADC sample.
- `rd_faddr`  in  ADDR_WIDTH  FIFO read pointer; asynchronous to `clk`.
- `fifo_wr`  out  1  FIFO write enable (`d_valid`).
- `fifo_data`  out  16  FIFO write data.
- `level`  out  ADDR_WIDTH  FIFO occupancy estimate.
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  high in DONE.
- `overflow`  out  1  high in OVF.
- `captured`  out  CNT_WIDTH  samples written in the current/last capture.

## Operation
- States:
  - IDLE: `start` -> ARMED.
  - ARMED: leave on trigger. If `trig_mode` = 0, leave on the first cycle. If `trig_mode` = 1, leave on the cycle after a rising edge of registered `trig`. Target is CAPTURE if latched `num_samples` ≠ 0, else DONE.
  - CAPTURE: exit to DONE when `captured` reaches `num_samples`; exit to OVF on overflow.
  - DONE / OVF: `start` -> ARMED; `abort` -> IDLE.
- `abort` has priority over every other transition.
- `start`, `decim`, `num_samples` and `trig_mode` are latched on the accepted `start`. Later changes have no effect until the next `start`.
- Decimation:
  - Counter is reset to 0 on entry to CAPTURE.
  - A sample is kept when `adc_valid` is high and the counter = 0.
  - Counter increments on each `adc_valid` and wraps at `decim`−1.
- Write pointer:
  - Internal `wptr` mirrors the FIFO write pointer: +1 per `fifo_wr`, wraps modulo 2^ADDR_WIDTH.
  - `wptr` resets only on `reset`, never on `start`.
- Read pointer sync:
  - `rd_faddr` passes through a 2-flop synchronizer.
  - The synchronized value is accepted into `rptr` only when two consecutive synchronized samples are equal. Otherwise `rptr` holds.
- Level: `level = wptr − rptr`, modulo 2^ADDR_WIDTH. The FIFO is full at `level` = 2^ADDR_WIDTH−1 (one slot reserved).
- Overflow:
  - Condition: a kept sample arrives while `level` = 2^ADDR_WIDTH−1.
  - The sample is dropped, no `fifo_wr` is issued, and the state goes to OVF.
  - `captured` holds the count of samples actually written.
- `captured` clears on entry to CAPTURE and increments with each `fifo_wr`.

## Timing
- Reset values: state IDLE, `fifo_wr` 0, `fifo_data` 0, `level` 0, `busy`/`done`/`overflow` 0, `captured` 0, `wptr`/`rptr` 0.
- All outputs are registered.
- Write latency:
  - A kept `adc_valid` in cycle n gives `fifo_wr` = 1 and `fifo_data` = that sample in cycle n+1.
  - `fifo_wr` is a single-cycle pulse per sample.
- Last sample: the final `fifo_wr` and the entry to DONE occur in the same cycle (n+1). `captured` = `num_samples` in that same cycle.
- Abort: `abort` in cycle n gives IDLE and `fifo_wr` = 0 in cycle n+1. A kept sample arriving in cycle n is not written.
- Trigger: `trig` rise at cycle n is seen in the edge register at n+1, giving CAPTURE at n+2. The first sample eligible for keeping is at n+2.
- Level sees `rptr` changes after 3–4 cycles. The estimate is conservative (over-reports) because the read pointer only lags.
- Simultaneous `start` and `abort`: abort wins.
- Simultaneous final write and overflow: cannot occur, because overflow is evaluated before the write is issued.

## Structure
- Package `adc_ctrl_pkg`:
  - state enum (IDLE, ARMED, CAPTURE, DONE, OVF);
  - `FIFO_DEPTH = 2**ADDR_WIDTH`;
  - `FIFO_FULL_LVL = FIFO_DEPTH-1`.
- Sub-module `fifo_level_mon` contains:
  - the `rd_faddr` synchronizer and stability filter;
  - `wptr`;
  - the `level` subtraction and full flag.
- Top level contains the FSM, decimator, counters and output registers.

## Test plan
- Immediate capture: `trig_mode`=0, `decim`=1, `num_samples`=10, continuous `adc_valid` with ramp data 0..
  - Required: 10 `fifo_wr` pulses with data 0..9, each one cycle after its `adc_valid`.
  - Required: `done`=1 in the cycle of the 10th write; `captured`=10.
- Decimation: `decim`=4, `num_samples`=3, `adc_valid` every cycle, data 0..
  - Required: written data 0, 4, 8.
  - `decim`=0 repeat: behaves as 1.
- External trigger: `trig_mode`=1; pulse `trig` at cycle 20.
  - Required: no writes before cycle 22; the first write is the sample from cycle 22.
- Overflow: `ADDR_WIDTH`=4, `rd_faddr` held 0, `num_samples`=100.
  - Required: exactly 15 writes, then `overflow`=1, `captured`=15, and no further `fifo_wr`.
  - Required: with `rd_faddr` advanced to 5, `start` recaptures 5 more samples before OVF.
- Abort and edge cases:
  - `abort` mid-CAPTURE after 4 writes: IDLE next cycle, no further writes, `captured`=4.
  - `num_samples`=0: ARMED -> DONE with no writes.
  - `start` while `busy`: ignored.
  - `reset` low mid-capture: all outputs return to reset values on the next edge.
